// File: rtl/fifo_flex_if.sv
// Handshake and status bundle between the UART data path and fifo_flex.
interface fifo_flex_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) ();

   logic                  clr;
   logic                  wr;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  rd;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output clr, wr, w_data, rd,
      input  r_data, r_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  clr, wr, w_data, rd,
      output r_data, r_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with registered or first-word-fall-through
// read, occupancy thresholds, sticky error flags and synchronous flush.
module fifo_flex #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter bit          FWFT       = 1'b0,
   parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 1,
   parameter int unsigned AE_LEVEL   = 1
) (
   input  logic       clk,
   input  logic       reset,
   fifo_flex_if.slave bus
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;
   localparam int unsigned PW    = ADDR_WIDTH + 1;

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         count_c;
   logic [ADDR_WIDTH-1:0] wr_idx;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  empty_c;
   logic                  full_c;
   logic                  rd_ok;
   logic                  wr_ok;
   logic                  overflow_q;
   logic                  underflow_q;

   // Occupancy and acceptance; a read from a full FIFO frees the slot for a same-cycle write.
   always_comb begin
      count_c = wr_ptr - rd_ptr;
      empty_c = (count_c == '0);
      full_c  = (count_c == PW'(DEPTH));
      rd_ok   = bus.rd && !empty_c;
      wr_ok   = bus.wr && (!full_c || rd_ok);
      wr_idx  = wr_ptr[ADDR_WIDTH-1:0];
      rd_idx  = rd_ptr[ADDR_WIDTH-1:0];
   end

   assign bus.count        = count_c;
   assign bus.empty        = empty_c;
   assign bus.full         = full_c;
   assign bus.almost_full  = (32'(count_c) >= AF_LEVEL);
   assign bus.almost_empty = (32'(count_c) <= AE_LEVEL);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

   // Pointers and sticky error flags; flush overrides any same-cycle access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.clr) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (rd_ok)
            rd_ptr <= rd_ptr + PW'(1);
         if (bus.wr && !wr_ok)
            overflow_q <= 1'b1;
         if (bus.rd && empty_c)
            underflow_q <= 1'b1;
      end
   end

   // Storage array; cleared only by reset, flush leaves contents in place.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (!bus.clr && wr_ok) begin
         mem[wr_idx] <= bus.w_data;
      end
   end

   generate
      if (FWFT == 1'b0) begin : g_reg_read
         logic [DATA_WIDTH-1:0] r_data_q;
         logic                  r_valid_q;

         // Registered read port; captures pre-write slot contents on a same-cycle collision.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_data_q  <= '0;
               r_valid_q <= 1'b0;
            end else if (bus.clr) begin
               r_valid_q <= 1'b0;
            end else if (rd_ok) begin
               r_data_q  <= mem[rd_idx];
               r_valid_q <= 1'b1;
            end else begin
               r_valid_q <= 1'b0;
            end
         end

         assign bus.r_data  = r_data_q;
         assign bus.r_valid = r_valid_q;
      end else begin : g_fwft_read
         assign bus.r_data  = mem[rd_idx];
         assign bus.r_valid = !empty_c;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex across default, small registered, FWFT and threshold configurations.
module tb_fifo_flex;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;

   fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_def ();
   fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_reg ();
   fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_fw  ();
   fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus_thr ();

   fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_def (
      .clk(clk), .reset(reset), .bus(bus_def.slave));
   fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1'b0)) u_reg (
      .clk(clk), .reset(reset), .bus(bus_reg.slave));
   fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1'b1)) u_fw (
      .clk(clk), .reset(reset), .bus(bus_fw.slave));
   fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1'b0), .AF_LEVEL(6), .AE_LEVEL(2)) u_thr (
      .clk(clk), .reset(reset), .bus(bus_thr.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation and tally the outcome.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] q [$];
   logic [7:0] exp_word;
   logic       do_wr;
   logic       do_rd;
   logic       m_rd_ok;
   logic       m_wr_ok;
   int         n_written;
   int         cnt;

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset    = 1'b1;
      {bus_def.clr, bus_def.wr, bus_def.rd, bus_def.w_data} = '0;
      {bus_reg.clr, bus_reg.wr, bus_reg.rd, bus_reg.w_data} = '0;
      {bus_fw.clr,  bus_fw.wr,  bus_fw.rd,  bus_fw.w_data}  = '0;
      {bus_thr.clr, bus_thr.wr, bus_thr.rd, bus_thr.w_data} = '0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();

      // Reset then idle, default geometry
      check("def_empty",     32'(bus_def.empty), 32'd1);
      check("def_full",      32'(bus_def.full), 32'd0);
      check("def_count",     32'(bus_def.count), 32'd0);
      check("def_aempty",    32'(bus_def.almost_empty), 32'd1);
      check("def_afull",     32'(bus_def.almost_full), 32'd0);
      check("def_rdata",     32'(bus_def.r_data), 32'd0);
      check("def_rvalid",    32'(bus_def.r_valid), 32'd0);
      check("def_overflow",  32'(bus_def.overflow), 32'd0);
      check("def_underflow", 32'(bus_def.underflow), 32'd0);
      check("fw_rst_rdata",  32'(bus_fw.r_data), 32'd0);
      check("fw_rst_rvalid", 32'(bus_fw.r_valid), 32'd0);

      // Fill then overflow on a 4-deep registered FIFO
      bus_reg.wr = 1'b1;
      bus_reg.w_data = 8'h11; tick();
      bus_reg.w_data = 8'h22; tick();
      bus_reg.w_data = 8'h33; tick();
      bus_reg.w_data = 8'h44; tick();
      check("fill_full_before_ovf", 32'(bus_reg.full), 32'd1);
      check("fill_ovf_before",      32'(bus_reg.overflow), 32'd0);
      bus_reg.w_data = 8'h55; tick();
      bus_reg.wr = 1'b0;
      check("fill_full",     32'(bus_reg.full), 32'd1);
      check("fill_count",    32'(bus_reg.count), 32'd4);
      check("fill_overflow", 32'(bus_reg.overflow), 32'd1);
      check("fill_rvalid0",  32'(bus_reg.r_valid), 32'd0);

      bus_reg.rd = 1'b1;
      tick(); check("rd1_data", 32'(bus_reg.r_data), 32'h11); check("rd1_valid", 32'(bus_reg.r_valid), 32'd1);
      tick(); check("rd2_data", 32'(bus_reg.r_data), 32'h22); check("rd2_valid", 32'(bus_reg.r_valid), 32'd1);
      tick(); check("rd3_data", 32'(bus_reg.r_data), 32'h33); check("rd3_valid", 32'(bus_reg.r_valid), 32'd1);
      tick(); check("rd4_data", 32'(bus_reg.r_data), 32'h44); check("rd4_valid", 32'(bus_reg.r_valid), 32'd1);
      bus_reg.rd = 1'b0;
      check("drain_empty",     32'(bus_reg.empty), 32'd1);
      check("drain_underflow", 32'(bus_reg.underflow), 32'd0);
      tick();
      check("idle_rvalid", 32'(bus_reg.r_valid), 32'd0);
      check("idle_rdata_hold", 32'(bus_reg.r_data), 32'h44);

      // Simultaneous read and write on a full FIFO
      bus_reg.wr = 1'b1;
      bus_reg.w_data = 8'h01; tick();
      bus_reg.w_data = 8'h02; tick();
      bus_reg.w_data = 8'h03; tick();
      bus_reg.w_data = 8'h04; tick();
      bus_reg.rd = 1'b1;
      bus_reg.w_data = 8'hAA; tick();
      bus_reg.wr = 1'b0;
      check("full_rw_count", 32'(bus_reg.count), 32'd4);
      check("full_rw_rdata", 32'(bus_reg.r_data), 32'h01);
      tick(); check("full_rw_d2", 32'(bus_reg.r_data), 32'h02);
      tick(); check("full_rw_d3", 32'(bus_reg.r_data), 32'h03);
      tick(); check("full_rw_d4", 32'(bus_reg.r_data), 32'h04);
      tick(); check("full_rw_dAA", 32'(bus_reg.r_data), 32'hAA);
      bus_reg.rd = 1'b0;
      check("full_rw_empty", 32'(bus_reg.empty), 32'd1);

      // Simultaneous read and write on an empty FIFO
      bus_reg.rd = 1'b1;
      bus_reg.wr = 1'b1;
      bus_reg.w_data = 8'h5C; tick();
      bus_reg.wr = 1'b0;
      check("empty_rw_count",     32'(bus_reg.count), 32'd1);
      check("empty_rw_underflow", 32'(bus_reg.underflow), 32'd1);
      check("empty_rw_rvalid",    32'(bus_reg.r_valid), 32'd0);
      tick();
      bus_reg.rd = 1'b0;
      check("empty_rw_rdata",  32'(bus_reg.r_data), 32'h5C);
      check("empty_rw_rvalid2", 32'(bus_reg.r_valid), 32'd1);

      // Flush with 3 words stored, overflow still sticky, write in the flush cycle
      bus_reg.wr = 1'b1;
      bus_reg.w_data = 8'h61; tick();
      bus_reg.w_data = 8'h62; tick();
      bus_reg.w_data = 8'h63; tick();
      check("pre_clr_count",    32'(bus_reg.count), 32'd3);
      check("pre_clr_overflow", 32'(bus_reg.overflow), 32'd1);
      bus_reg.clr = 1'b1;
      bus_reg.w_data = 8'h77; tick();
      bus_reg.clr = 1'b0;
      bus_reg.wr  = 1'b0;
      check("clr_count",     32'(bus_reg.count), 32'd0);
      check("clr_empty",     32'(bus_reg.empty), 32'd1);
      check("clr_overflow",  32'(bus_reg.overflow), 32'd0);
      check("clr_underflow", 32'(bus_reg.underflow), 32'd0);
      check("clr_rvalid",    32'(bus_reg.r_valid), 32'd0);
      tick();
      check("post_clr_count", 32'(bus_reg.count), 32'd0);

      // First-word-fall-through
      bus_fw.wr = 1'b1;
      bus_fw.w_data = 8'h3C; tick();
      bus_fw.wr = 1'b0;
      check("fw_rdata",  32'(bus_fw.r_data), 32'h3C);
      check("fw_rvalid", 32'(bus_fw.r_valid), 32'd1);
      bus_fw.rd = 1'b1; tick();
      bus_fw.rd = 1'b0;
      check("fw_pop_empty",     32'(bus_fw.empty), 32'd1);
      check("fw_pop_rvalid",    32'(bus_fw.r_valid), 32'd0);
      check("fw_pop_underflow", 32'(bus_fw.underflow), 32'd0);
      bus_fw.rd = 1'b1;
      bus_fw.wr = 1'b1;
      bus_fw.w_data = 8'h5C; tick();
      bus_fw.rd = 1'b0;
      bus_fw.wr = 1'b0;
      check("fw_rw_rdata",     32'(bus_fw.r_data), 32'h5C);
      check("fw_rw_rvalid",    32'(bus_fw.r_valid), 32'd1);
      check("fw_rw_underflow", 32'(bus_fw.underflow), 32'd1);
      check("fw_rw_count",     32'(bus_fw.count), 32'd1);

      // Pointer wrap and thresholds: 7 writes, 13 read+write, 7 reads
      n_written = 0;
      for (int c = 0; c < 27; c++) begin
         do_wr = (c < 20);
         do_rd = (c >= 7);
         cnt     = q.size();
         m_rd_ok = do_rd && (cnt > 0);
         m_wr_ok = do_wr && ((cnt < 8) || m_rd_ok);
         exp_word = 8'h00;
         if (m_rd_ok)
            exp_word = q.pop_front();
         bus_thr.wr     = do_wr;
         bus_thr.rd     = do_rd;
         bus_thr.w_data = 8'(n_written * 13 + 5);
         if (m_wr_ok) begin
            q.push_back(bus_thr.w_data);
            n_written++;
         end
         tick();
         cnt = q.size();
         check($sformatf("thr_count_c%0d", c), 32'(bus_thr.count), 32'(cnt));
         check($sformatf("thr_af_c%0d", c), 32'(bus_thr.almost_full), 32'(cnt >= 6));
         check($sformatf("thr_ae_c%0d", c), 32'(bus_thr.almost_empty), 32'(cnt <= 2));
         if (m_rd_ok) begin
            check($sformatf("thr_rdata_c%0d", c), 32'(bus_thr.r_data), 32'(exp_word));
            check($sformatf("thr_rvalid_c%0d", c), 32'(bus_thr.r_valid), 32'd1);
         end
      end
      bus_thr.wr = 1'b0;
      bus_thr.rd = 1'b0;
      check("thr_written", 32'(n_written), 32'd20);
      check("thr_underflow", 32'(bus_thr.underflow), 32'd0);
      check("thr_overflow",  32'(bus_thr.overflow), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised synchronous FIFO for the UART TX/RX data paths. It replaces the fixed 4-entry buffer with:
- configurable depth;
- a selectable read mode: registered read or first-word-fall-through;
- an occupancy count and programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags and a synchronous flush.

It sits between the UART baud-rate receiver/transmitter and the host-side register interface.

Parameters:
DATA_WIDTH, 8, word width in bits.
ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH, legal range 1..10.
FWFT, 0, 0 = registered read (data one cycle after rd); 1 = first-word-fall-through (head word always on r_data).
AF_LEVEL, 2**ADDR_WIDTH-1, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
clr  in  1  synchronous flush, active-high.
wr  in  1  write request.
w_data  in  DATA_WIDTH  write data.
rd  in  1  read request / pop.
r_data  out  DATA_WIDTH  read data.
r_valid  out  1  r_data holds a freshly popped word (FWFT=0); equals !empty (FWFT=1).
full  out  1  count == 2**ADDR_WIDTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
overflow  out  1  sticky: write attempted while it could not be accepted.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset: reset, clock clk. reset is asynchronous, active-high. On reset:
  - rd_ptr and wr_ptr cleared (each ADDR_WIDTH+1 bits, MSB is the wrap bit);
  - all memory entries cleared to 0;
  - r_data=0, r_valid=0 (FWFT=0);
  - count=0, empty=1, full=0, almost_empty=1;
  - almost_full = (AF_LEVEL==0);
  - overflow=0, underflow=0.
- count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1). All flags are combinational from the pointers; only the sticky bits are registered.
- Read acceptance: rd_ok = rd && !empty.
- Write acceptance: wr_ok = wr && (!full || rd_ok). When full, a simultaneous accepted read frees the slot, so both complete and count is unchanged.
- When empty with rd and wr together: the write is accepted, the read is rejected and underflow sets. In FWFT=1 the written word appears on r_data the next cycle.
- Write: mem[wr_ptr[ADDR_WIDTH-1:0]] <= w_data; wr_ptr increments. Pointer wrap is natural binary overflow.
- Read, FWFT=0:
  - on rd_ok, r_data <= mem[rd_ptr index] (old contents, even if a same-cycle write targets that slot); rd_ptr increments; r_valid <= 1;
  - otherwise r_valid <= 0 and r_data holds its value;
  - latency: rd at edge N gives data/r_valid during cycle N+1.
- Read, FWFT=1:
  - r_data = mem[rd_ptr index] combinationally, r_valid = !empty;
  - rd_ok advances rd_ptr;
  - write-to-visible latency is 1 cycle.
- Error flags: overflow sets on wr && !wr_ok; underflow sets on rd && empty. Both stay set until reset or clr.
- clr (synchronous, highest priority over wr/rd in the same cycle):
  - pointers and sticky flags zeroed; memory not cleared;
  - FWFT=0: r_valid <= 0, r_data holds;
  - wr/rd in the clr cycle are ignored and do not set error flags.
- Reset asserted mid-operation aborts immediately; any in-flight read is discarded.
- No state machine beyond the pointers. The block must synthesise for both FWFT values.

Test Plan:
- Reset then idle: with defaults (ADDR_WIDTH=4) -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, r_data=0, overflow=underflow=0.
- Fill/overflow (FWFT=0, ADDR_WIDTH=2): write 0x11,0x22,0x33,0x44, then write 0x55 ->
  - full=1, count=4, overflow=1, 0x55 dropped;
  - then 4 reads -> r_data 0x11,0x22,0x33,0x44, each one cycle after rd with r_valid=1;
  - empty=1 after the 4th read.
- Simultaneous access:
  - full FIFO, rd+wr 0xAA -> count stays 4, 0xAA read out last;
  - empty FIFO, rd+wr 0x5C -> count=1, underflow=1, r_valid=0.
- FWFT=1: write 0x3C to an empty FIFO -> next cycle r_data=0x3C, r_valid=1; pulse rd -> empty=1, r_valid=0.
- Wrap and thresholds (ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2): stream 20 words with interleaved reads ->
  - data order preserved across pointer wrap;
  - almost_full toggles exactly at count 6, almost_empty exactly at count 2.
- clr with 3 words stored plus overflow set, with wr asserted in the clr cycle -> next cycle count=0, empty=1, overflow=0, write ignored.
